// File: rtl/kbd_fifo_68k_pkg.sv
// kbd_pkg: shared definitions for the keyboard event buffer.
//   - register offsets decoded from cpu_a[1]
//   - STATUS register bit positions
//   - FIFO entry width ({pressed, extended, scancode})
//   - bus access tracker state encoding
//   - status_word(): assembles the STATUS read value
package kbd_pkg;

  localparam logic KBD_STATUS = 1'b0;
  localparam logic KBD_DATA   = 1'b1;

  localparam int ST_NE  = 0;
  localparam int ST_OVF = 1;
  localparam int ST_IE  = 2;

  localparam int ENTRY_W = 10;

  typedef enum logic [2:0] {
    ACC_SYNC    = 3'd0,
    ACC_IDLE    = 3'd1,
    ACC_WR_WAIT = 3'd2,
    ACC_POP     = 3'd3,
    ACC_HOLD    = 3'd4
  } acc_state_t;

  function automatic logic [15:0] status_word(input logic ie, input logic ovf, input logic ne);
    logic [15:0] w;
    w         = '0;
    w[ST_IE]  = ie;
    w[ST_OVF] = ovf;
    w[ST_NE]  = ne;
    return w;
  endfunction

endpackage

// File: rtl/kbd_fifo_68k_if.sv
// kbd_fifo_68k_if: CPU-side register bus of the keyboard buffer.
//   sel   chip select (address decoded, cpu_as_n low)
//   rw    1 = read, 0 = write
//   reg_a register select: 0 = STATUS, 1 = DATA
//   lds_n lower data strobe, writes act only when low
//   din   CPU write data
//   dout  read data, 0 when not selected
//   irq   level interrupt request
interface kbd_fifo_68k_if;
  logic        sel;
  logic        rw;
  logic        reg_a;
  logic        lds_n;
  logic [15:0] din;
  logic [15:0] dout;
  logic        irq;

  modport master (output sel, rw, reg_a, lds_n, din, input dout, irq);
  modport slave  (input sel, rw, reg_a, lds_n, din, output dout, irq);
endinterface

// File: rtl/kbd_fifo_68k_sync_fifo.sv
// sync_fifo: single-clock FIFO of 2^DEPTH_BITS entries.
//   clk, reset_n  clock, async active-low reset
//   push_i        write wdata_i (caller must not push when full unless popping)
//   pop_i         drop the head entry (ignored when empty)
//   wdata_i       entry to write
//   rdata_o       current head entry (valid when not empty)
//   full_o        count == 2^DEPTH_BITS
//   empty_o       count == 0
//   count_o       number of stored entries
// Pointers and count are DEPTH_BITS+1 wide; the storage index uses the low
// DEPTH_BITS bits, so the index wraps modulo the depth.
module sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   count_o
);

  localparam int                  DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] ONE      = (DEPTH_BITS + 1)'(1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wdata_i;
  end

  // Pointer distance must always equal the occupancy counter.
  assert property (@(posedge clk) disable iff (!reset_n) (wr_ptr_q - rd_ptr_q) == count_q);

endmodule

// File: rtl/kbd_fifo_68k.sv
// kbd_fifo_68k: PS/2 keyboard event buffer presented to the fx68k as a
// two-register peripheral (STATUS, DATA) with a level interrupt.
//   clk      CPU clock, the only clock
//   reset_n  async active-low reset
//   ps2_key  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   bus      register bus (sel/rw/reg_a/lds_n/din in, dout/irq out)
//
// Bus access tracker:
//   state       | meaning
//   ACC_SYNC    | after reset, wait for sel low before tracking accesses
//   ACC_IDLE    | no access in progress; sel rising starts one
//   ACC_WR_WAIT | write access started, lower data strobe not yet seen
//   ACC_POP     | DATA read of a non-empty FIFO; pop when sel falls
//   ACC_HOLD    | access already handled, wait for sel to fall
module kbd_fifo_68k
  import kbd_pkg::*;
#(
  parameter int c_depth_bits = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [10:0]     ps2_key,
  kbd_fifo_68k_if.slave   bus
);

  logic [10:0]          key_q;
  logic                 strobe_prev_q;
  logic                 armed_q;
  logic                 ie_q, ie_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q;
  acc_state_t           state_q, state_d;

  logic                 push_evt;
  logic                 pop;
  logic                 wr_status;
  logic                 fifo_push;
  logic                 drop;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [c_depth_bits:0] fifo_count;
  logic [15:0]          dout_d;
  logic                 unused_ok;

  // Input capture register; not reset so that the first cycle after reset
  // already sees the live toggle level and arming cannot fake an event.
  always_ff @(posedge clk) begin
    key_q <= ps2_key;
  end

  assign push_evt  = armed_q & (key_q[10] ^ strobe_prev_q);
  assign fifo_push = push_evt & (~fifo_full | pop);
  assign drop      = push_evt & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_BITS (c_depth_bits)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .wdata_i (key_q[ENTRY_W-1:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    wr_status = 1'b0;
    unique case (state_q)
      ACC_SYNC: begin
        if (!bus.sel) state_d = ACC_IDLE;
      end
      ACC_IDLE: begin
        if (bus.sel) begin
          if (bus.rw) begin
            // Empty at access start means no pop, even if an entry lands later.
            if (bus.reg_a == KBD_DATA && !fifo_empty) state_d = ACC_POP;
            else                                       state_d = ACC_HOLD;
          end else if (!bus.lds_n) begin
            wr_status = (bus.reg_a == KBD_STATUS);
            state_d   = ACC_HOLD;
          end else begin
            state_d = ACC_WR_WAIT;
          end
        end
      end
      ACC_WR_WAIT: begin
        if (!bus.sel) begin
          state_d = ACC_IDLE;
        end else if (!bus.rw && !bus.lds_n) begin
          wr_status = (bus.reg_a == KBD_STATUS);
          state_d   = ACC_HOLD;
        end
      end
      ACC_POP: begin
        if (!bus.sel) begin
          pop     = 1'b1;
          state_d = ACC_IDLE;
        end
      end
      ACC_HOLD: begin
        if (!bus.sel) state_d = ACC_IDLE;
      end
      default: state_d = ACC_SYNC;
    endcase
  end

  always_comb begin
    ie_d  = ie_q;
    ovf_d = ovf_q;
    if (wr_status) begin
      ie_d = bus.din[ST_IE];
      if (bus.din[ST_OVF]) ovf_d = 1'b0;
    end
    // A dropped event outranks a clear arriving in the same cycle.
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_prev_q <= 1'b0;
      armed_q       <= 1'b0;
      ie_q          <= 1'b0;
      ovf_q         <= 1'b0;
      irq_q         <= 1'b0;
      state_q       <= ACC_SYNC;
    end else begin
      strobe_prev_q <= key_q[10];
      armed_q       <= 1'b1;
      ie_q          <= ie_d;
      ovf_q         <= ovf_d;
      irq_q         <= ie_q & ~fifo_empty;
      state_q       <= state_d;
    end
  end

  always_comb begin
    dout_d = '0;
    if (bus.sel && bus.rw) begin
      if (bus.reg_a == KBD_DATA) begin
        if (!fifo_empty) dout_d = {{(16 - ENTRY_W){1'b0}}, fifo_head};
      end else begin
        dout_d = status_word(ie_q, ovf_q, ~fifo_empty);
      end
    end
  end

  assign bus.dout = dout_d;
  assign bus.irq  = irq_q;

  assign unused_ok = ^{fifo_count, bus.din[15:3], bus.din[0]};

endmodule

// File: tb/tb_kbd_fifo_68k.sv
module tb_kbd_fifo_68k;
  import kbd_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;

  kbd_fifo_68k_if bus ();

  kbd_fifo_68k #(.c_depth_bits(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];
  logic       ie_m  = 1'b0;
  logic       ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive a new key event (called at a negedge); update the model.
  task automatic toggle_key(input logic p, input logic e, input logic [7:0] code);
    logic [9:0] ent;
    ent     = {p, e, code};
    ps2_key = {~ps2_key[10], ent};
    if (exp_q.size() < 16) exp_q.push_back(ent);
    else                   ovf_m = 1'b1;
  endtask

  task automatic push_event(input logic p, input logic e, input logic [7:0] code);
    @(negedge clk);
    toggle_key(p, e, code);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic r, output logic [15:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = r; bus.lds_n = 1'b1;
    #1 d = bus.dout;
    @(posedge clk);
    @(negedge clk);
    bus.sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b0; bus.reg_a = KBD_STATUS; bus.lds_n = 1'b0; bus.din = d;
    @(posedge clk);
    @(negedge clk);
    bus.sel = 1'b0; bus.rw = 1'b1; bus.lds_n = 1'b1;
    ie_m = d[ST_IE];
    if (d[ST_OVF]) ovf_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_status_chk(input string tag);
    logic [15:0] d;
    cpu_read(KBD_STATUS, d);
    chk(tag, d, {13'b0, ie_m, ovf_m, exp_q.size() != 0});
  endtask

  task automatic read_data_chk(input string tag);
    logic [15:0] d;
    logic [15:0] e;
    e = 16'h0000;
    if (exp_q.size() != 0) e = {6'b0, exp_q[0]};
    cpu_read(KBD_DATA, d);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk(tag, d, e);
  endtask

  initial begin
    logic [15:0] e;
    int n;
    bus.sel = 1'b0; bus.rw = 1'b1; bus.reg_a = 1'b0; bus.lds_n = 1'b1; bus.din = '0;
    ps2_key = '0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout, 16'h0000);
    chk("rst_irq", {15'b0, bus.irq}, 16'h0000);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = KBD_STATUS;
    #1 chk("rst_status", bus.dout, 16'h0000);
    bus.sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    read_status_chk("arm_status");

    // Single event
    push_event(1'b1, 1'b0, 8'h1C);
    read_status_chk("single_status");
    cpu_read(KBD_DATA, e);
    chk("single_data", e, 16'h021C);
    void'(exp_q.pop_front());
    read_status_chk("single_after");

    // Ordering and pointer wrap: batches of 7/7/6
    n = 0;
    foreach (exp_q[i]) n = n;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < ((b == 2) ? 6 : 7); i++) begin
        push_event(n[0], n[1], 8'h20 + 8'(n));
        n++;
      end
      read_status_chk("batch_status");
      for (int i = 0; i < ((b == 2) ? 6 : 7); i++) read_data_chk("batch_data");
      read_status_chk("batch_drained");
    end

    // Overflow: 17 pushes, 16 kept
    for (int i = 0; i < 17; i++) push_event(1'b0, i[0], 8'h40 + 8'(i));
    read_status_chk("ovf_status");
    cpu_write(16'h0002);
    read_status_chk("ovf_cleared");
    for (int i = 0; i < 16; i++) read_data_chk("ovf_data");
    read_status_chk("ovf_drained");

    // Interrupt timing
    cpu_write(16'h0004);
    read_status_chk("ie_status");
    @(negedge clk);
    toggle_key(1'b1, 1'b1, 8'h5A);
    @(posedge clk);
    @(posedge clk);
    #1 chk("irq_early", {15'b0, bus.irq}, 16'h0000);
    @(posedge clk);
    #1 chk("irq_rise", {15'b0, bus.irq}, 16'h0001);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = KBD_DATA; bus.lds_n = 1'b1;
    e = {6'b0, exp_q.pop_front()};
    #1 chk("irq_data", bus.dout, e);
    @(posedge clk);
    @(negedge clk);
    bus.sel = 1'b0;
    @(posedge clk);
    #1 chk("irq_hold", {15'b0, bus.irq}, 16'h0001);
    @(posedge clk);
    #1 chk("irq_fall", {15'b0, bus.irq}, 16'h0000);
    cpu_write(16'h0000);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_event(1'b1, 1'b0, 8'h60 + 8'(i));
    read_status_chk("full_status");
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = KBD_DATA; bus.lds_n = 1'b1;
    e = {6'b0, exp_q.pop_front()};
    #1 chk("full_head", bus.dout, e);
    @(posedge clk);
    @(negedge clk);
    toggle_key(1'b1, 1'b1, 8'h7F);
    @(posedge clk);
    @(negedge clk);
    bus.sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    read_status_chk("simul_status");
    for (int i = 0; i < 16; i++) read_data_chk("simul_data");
    read_status_chk("simul_drained");
    read_data_chk("empty_data");

    // Long access, then reset in the middle of an access
    cpu_write(16'h0004);
    push_event(1'b0, 1'b0, 8'h11);
    push_event(1'b1, 1'b0, 8'h22);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = KBD_DATA; bus.lds_n = 1'b1;
    e = {6'b0, exp_q[0]};
    #1 chk("long_first", bus.dout, e);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1 chk("long_hold", bus.dout, e);
    end
    @(negedge clk);
    bus.sel = 1'b0;
    void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    read_status_chk("long_one_pop");
    #1 chk("irq_pre_rst", {15'b0, bus.irq}, 16'h0001);
    @(negedge clk);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.reg_a = KBD_DATA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    ie_m = 1'b0;
    ovf_m = 1'b0;
    #1;
    chk("rst_mid_dout", bus.dout, 16'h0000);
    chk("rst_mid_irq", {15'b0, bus.irq}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("post_rst_dout", bus.dout, 16'h0000);
    toggle_key(1'b0, 1'b1, 8'h33);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 chk("post_rst_head", bus.dout, {6'b0, exp_q[0]});
    bus.sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    read_status_chk("post_rst_status");
    read_data_chk("post_rst_data");
    read_status_chk("post_rst_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
